// File: rtl/dwt_pkg.sv
// Shared definitions for the LeGall 5/3 line lifting engine.
//   DWT_FWD / DWT_INV : values of the mode input (forward / inverse transform)
//   dwt_state_t       : line-sequencer state encoding
//   dwt_clog2         : ceiling log2 for sizing the pair index (minimum 1 bit)
package dwt_pkg;

    localparam logic DWT_FWD = 1'b0;
    localparam logic DWT_INV = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4
    } dwt_state_t;

    function automatic int dwt_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lift53_step.sv
// Combinational 5/3 lifting step for one output pair.
//   i_mode        : DWT_FWD computes (s, d) from (x_even, x_odd); DWT_INV the reverse
//   i_even/i_odd  : current pair (forward: x[2n], x[2n+1]; inverse: s[n], d[n])
//   i_d_prev      : d[n-1] carried from the previous step
//   i_next_even   : next pair's even word (forward: x[2n+2]; inverse: s[n+1])
//   i_next_odd    : next pair's odd word (inverse only: d[n+1])
//   i_is_first    : n == 0, mirror d[-1] := d[0]
//   i_is_last     : n == N-1, mirror x[2N] := x[2N-2]; next_* are ignored
//   o_even/o_odd  : result pair (forward: s[n], d[n]; inverse: x[2n], x[2n+1])
//   o_d_cur       : d[n], to be carried as d_prev for the following step
module lift53_step
    import dwt_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              i_mode,
    input  logic [DATA_W-1:0] i_even,
    input  logic [DATA_W-1:0] i_odd,
    input  logic [DATA_W-1:0] i_d_prev,
    input  logic [DATA_W-1:0] i_next_even,
    input  logic [DATA_W-1:0] i_next_odd,
    input  logic              i_is_first,
    input  logic              i_is_last,
    output logic [DATA_W-1:0] o_even,
    output logic [DATA_W-1:0] o_odd,
    output logic [DATA_W-1:0] o_d_cur
);

    localparam int SW = DATA_W + 2;
    localparam logic signed [SW-1:0] C_TWO = SW'(2);

    function automatic logic signed [SW-1:0] sx(input logic [DATA_W-1:0] v);
        return {{2{v[DATA_W-1]}}, v};
    endfunction

    // floor((a + b) / 2), wrapped to DATA_W
    function automatic logic [DATA_W-1:0] pred_term(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        return DATA_W'((sx(a) + sx(b)) >>> 1);
    endfunction

    // floor((a + b + 2) / 4), wrapped to DATA_W
    function automatic logic [DATA_W-1:0] upd_term(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return DATA_W'((sx(a) + sx(b) + C_TWO) >>> 2);
    endfunction

    logic [DATA_W-1:0] w_f_next;
    logic [DATA_W-1:0] w_f_d;
    logic [DATA_W-1:0] w_f_dleft;
    logic [DATA_W-1:0] w_f_s;
    logic [DATA_W-1:0] w_i_dleft;
    logic [DATA_W-1:0] w_i_xe;
    logic [DATA_W-1:0] w_i_xe_next;
    logic [DATA_W-1:0] w_i_xo;

    // Forward: predict detail, then update approximation.
    assign w_f_next  = i_is_last ? i_even : i_next_even;
    assign w_f_d     = i_odd - pred_term(i_even, w_f_next);
    assign w_f_dleft = i_is_first ? w_f_d : i_d_prev;
    assign w_f_s     = i_even + upd_term(w_f_dleft, w_f_d);

    // Inverse: undo the update for this and the next even sample, then undo
    // the prediction. The next even sample needs d[n] and d[n+1].
    assign w_i_dleft   = i_is_first ? i_odd : i_d_prev;
    assign w_i_xe      = i_even - upd_term(w_i_dleft, i_odd);
    assign w_i_xe_next = i_is_last ? w_i_xe : (i_next_even - upd_term(i_odd, i_next_odd));
    assign w_i_xo      = i_odd + pred_term(w_i_xe, w_i_xe_next);

    assign o_even  = (i_mode == DWT_FWD) ? w_f_s : w_i_xe;
    assign o_odd   = (i_mode == DWT_FWD) ? w_f_d : w_i_xo;
    assign o_d_cur = (i_mode == DWT_INV) ? i_odd : w_f_d;

endmodule

// File: rtl/lifting_dwt53_line.sv
// Single-level 1-D LeGall 5/3 lifting engine, one line of LINE_LEN samples
// presented as N = LINE_LEN/2 (even, odd) pairs.
//   clk, rst_n             : clock, asynchronous active-low reset
//   mode                   : 0 forward, 1 inverse; latched on pair 0 of a line
//   in_valid/in_ready      : input pair handshake (in_even, in_odd)
//   out_valid/out_ready    : output pair handshake (out_even, out_odd, out_idx, out_last)
//   busy                   : a line is in progress
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer keeps data stable while valid && !ready. The output register is a
// single stage, so a new pair is refused while the output is stalled.
module lifting_dwt53_line
    import dwt_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int LINE_LEN = 16,
    localparam int N_PAIRS  = LINE_LEN / 2,
    localparam int IDX_W    = dwt_clog2(N_PAIRS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_even,
    input  logic [DATA_W-1:0] in_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_even,
    output logic [DATA_W-1:0] out_odd,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam logic [IDX_W-1:0] C_LAST_M1 = IDX_W'(N_PAIRS - 2);

    dwt_state_t        r_state;
    dwt_state_t        w_state_nxt;
    logic              r_mode;
    logic [DATA_W-1:0] r_even;
    logic [DATA_W-1:0] r_odd;
    logic [DATA_W-1:0] r_d_prev;
    logic [IDX_W-1:0]  r_cnt;       // index of the pair held in r_even/r_odd
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_even;
    logic [DATA_W-1:0] r_out_odd;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_out_last;

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_free;
    logic              w_step_load;
    logic              w_step_last;
    logic [DATA_W-1:0] w_step_even;
    logic [DATA_W-1:0] w_step_odd;
    logic [DATA_W-1:0] w_step_d;

    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_fire  = in_valid && w_in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_in_fire) w_state_nxt = ST_FILL;
            ST_FILL,
            ST_RUN:   if (w_in_fire) w_state_nxt = (r_cnt == C_LAST_M1) ? ST_FLUSH : ST_RUN;
            ST_FLUSH: if (w_out_free) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_in_ready  = 1'b0;
        w_step_load = 1'b0;
        w_step_last = 1'b0;
        case (r_state)
            ST_IDLE,
            ST_FILL:  w_in_ready = 1'b1;
            ST_RUN:   w_in_ready = w_out_free;
            default:  w_in_ready = 1'b0;
        endcase
        if ((r_state == ST_FILL || r_state == ST_RUN) && w_in_fire) begin
            w_step_load = 1'b1;
        end
        if (r_state == ST_FLUSH) begin
            w_step_last = 1'b1;
            w_step_load = w_out_free;
        end
    end

    lift53_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_mode      (r_mode),
        .i_even      (r_even),
        .i_odd       (r_odd),
        .i_d_prev    (r_d_prev),
        .i_next_even (in_even),
        .i_next_odd  (in_odd),
        .i_is_first  (r_cnt == '0),
        .i_is_last   (w_step_last),
        .o_even      (w_step_even),
        .o_odd       (w_step_odd),
        .o_d_cur     (w_step_d)
    );

    // Pair registers and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= 1'b0;
            r_even      <= '0;
            r_odd       <= '0;
            r_d_prev    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_even  <= '0;
            r_out_odd   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_in_fire) begin
                r_mode <= mode;
                r_even <= in_even;
                r_odd  <= in_odd;
                r_cnt  <= '0;
            end else if (w_step_load && !w_step_last) begin
                r_even   <= in_even;
                r_odd    <= in_odd;
                r_d_prev <= w_step_d;
                r_cnt    <= r_cnt + IDX_W'(1);
            end

            if (w_step_load) begin
                r_out_valid <= 1'b1;
                r_out_even  <= w_step_even;
                r_out_odd   <= w_step_odd;
                r_out_idx   <= r_cnt;
                r_out_last  <= w_step_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_even  = r_out_even;
    assign out_odd   = r_out_odd;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lifting_dwt53_line.sv
// Bench for lifting_dwt53_line: a 16-bit instance for the reference line and
// an 8-bit instance for wrap-around round trips, sharing all inputs.
module tb_lifting_dwt53_line;

    localparam int NP    = 8;
    localparam int EXP_W = 3 + 1 + 16 + 16;

    typedef struct packed {
        logic [15:0] xe;
        logic [15:0] xo;
        logic [15:0] s;
        logic [15:0] d;
    } vec_t;

    vec_t             tbl [NP];
    logic [15:0]      drv_a [NP];
    logic [15:0]      drv_b [NP];
    logic [EXP_W-1:0] exp_q [$];
    int               checks = 0;
    int               errors = 0;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_even;
    logic [15:0] in_odd;

    logic        in_ready16, out_valid16, out_last16, busy16;
    logic [15:0] out_even16, out_odd16;
    logic [2:0]  out_idx16;
    logic        in_ready8, out_valid8, out_last8, busy8;
    logic [7:0]  out_even8, out_odd8;
    logic [2:0]  out_idx8;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    lifting_dwt53_line #(.DATA_W(16), .LINE_LEN(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .in_even   (in_even),
        .in_odd    (in_odd),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .out_even  (out_even16),
        .out_odd   (out_odd16),
        .out_idx   (out_idx16),
        .out_last  (out_last16),
        .busy      (busy16)
    );

    lifting_dwt53_line #(.DATA_W(8), .LINE_LEN(16)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in_even   (in_even[7:0]),
        .in_odd    (in_odd[7:0]),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_even  (out_even8),
        .out_odd   (out_odd8),
        .out_idx   (out_idx8),
        .out_last  (out_last8),
        .busy      (busy8)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_vec(input int i, input int xe, input int xo, input int s, input int d);
        tbl[i].xe = 16'(xe);
        tbl[i].xo = 16'(xo);
        tbl[i].s  = 16'(s);
        tbl[i].d  = 16'(d);
    endtask

    // Load driver arrays and expected queue from the reference table.
    task automatic load_line(input logic inv);
        for (int i = 0; i < NP; i++) begin
            if (!inv) begin
                drv_a[i] = tbl[i].xe;
                drv_b[i] = tbl[i].xo;
                exp_q.push_back({3'(i), (i == NP - 1), tbl[i].s, tbl[i].d});
            end else begin
                drv_a[i] = tbl[i].s;
                drv_b[i] = tbl[i].d;
                exp_q.push_back({3'(i), (i == NP - 1), tbl[i].xe, tbl[i].xo});
            end
        end
    endtask

    // ---------------- driver + scoreboard ----------------
    // rdy_pat 0: out_ready always 1; 1: pattern 1,0,0,1 repeating.
    // flip_at >= 0: mode inverted for pairs after index flip_at.
    // stop_ptr >= 0: return once that many pairs have been accepted.
    task automatic run_line(input logic m, input int rdy_pat, input int flip_at,
                            input int stop_ptr, input logic sel, input string tag);
        int               ptr;
        int               cyc;
        logic             stall_prev;
        logic [31:0]      held;
        logic             rdy, ov, ol;
        logic [15:0]      oe, oo, msk;
        logic [2:0]       oi;
        logic [EXP_W-1:0] exp_v;
        ptr        = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        held       = '0;
        msk        = sel ? 16'h00FF : 16'hFFFF;
        while (1) begin
            @(negedge clk);
            if (ptr == stop_ptr) break;
            out_ready = (rdy_pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (ptr < NP) begin
                in_valid = 1'b1;
                in_even  = drv_a[ptr];
                in_odd   = drv_b[ptr];
                mode     = (flip_at >= 0 && ptr > flip_at) ? ~m : m;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (sel) begin
                rdy = in_ready8;  ov = out_valid8;  ol = out_last8;  oi = out_idx8;
                oe  = {8'h00, out_even8};  oo = {8'h00, out_odd8};
            end else begin
                rdy = in_ready16; ov = out_valid16; ol = out_last16; oi = out_idx16;
                oe  = out_even16;  oo = out_odd16;
            end
            if (stall_prev) begin
                check({tag, "_stall_hold"}, {31'd0, ov, oe, oo}, {31'd0, 1'b1, held});
            end
            if (ov && !out_ready) begin
                check({tag, "_ready_low"}, {63'd0, rdy}, 64'd0);
                stall_prev = 1'b1;
                held       = {oe, oo};
            end else begin
                stall_prev = 1'b0;
            end
            if (ov && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_extra_output actual=idx %0d required=none", tag, oi);
                end else begin
                    exp_v = exp_q.pop_front();
                    exp_v[31:16] = exp_v[31:16] & msk;
                    exp_v[15:0]  = exp_v[15:0] & msk;
                    check(tag, {28'd0, oi, ol, oe, oo}, {28'd0, exp_v});
                end
            end
            if (in_valid && rdy) ptr++;
            cyc++;
            if (ptr >= NP && exp_q.size() == 0) break;
            if (cyc >= 300) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout actual=%0d outputs pending required=0", tag, exp_q.size());
                exp_q.delete();
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_16"}, {out_valid16, out_even16, out_odd16, out_idx16, out_last16, busy16}, 64'd0);
        check({name, "_8"},  {out_valid8, out_even8, out_odd8, out_idx8, out_last8, busy8}, 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        set_vec(0,   0, 225,  94,  188);
        set_vec(1,  74, 150, 124,   11);
        set_vec(2, 204, 142, 187,  -80);
        set_vec(3, 240, 242, 223,   10);
        set_vec(4, 225,  82, 184, -175);
        set_vec(5, 289,  62, 209, -146);
        set_vec(6, 127, 126,  78,  -50);
        set_vec(7, 226,  27, 164, -199);

        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_even   = '0;
        in_odd    = '0;
        #1;
        check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Forward reference line, no stalls
        load_line(1'b0);
        run_line(1'b0, 0, -1, -1, 1'b0, "fwd");

        // Inverse of the reference coefficients
        load_line(1'b1);
        run_line(1'b1, 0, -1, -1, 1'b0, "inv");

        // Forward under output backpressure
        load_line(1'b0);
        run_line(1'b0, 1, -1, -1, 1'b0, "fwd_bp");

        // Mode raised after pair 3: line stays forward, next line is inverse
        load_line(1'b0);
        run_line(1'b0, 0, 3, -1, 1'b0, "fwd_flip");
        load_line(1'b1);
        run_line(1'b1, 0, -1, -1, 1'b0, "inv_after_flip");

        // Reset after pair 4 accepted, then a fresh forward line
        load_line(1'b0);
        run_line(1'b0, 0, -1, 5, 1'b0, "fwd_pre_rst");
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("post_reset_idle", {62'd0, out_valid16, busy16}, 64'd0);
        end
        load_line(1'b0);
        run_line(1'b0, 0, -1, -1, 1'b0, "fwd_after_rst");

        // 8-bit wrap: (127,-128) forward gives (-128,1); inverse restores it
        for (int i = 0; i < NP; i++) begin
            drv_a[i] = 16'h007F;
            drv_b[i] = 16'h0080;
            exp_q.push_back({3'(i), (i == NP - 1), 16'h0080, 16'h0001});
        end
        run_line(1'b0, 0, -1, -1, 1'b1, "wrap_fwd");
        for (int i = 0; i < NP; i++) begin
            drv_a[i] = 16'h0080;
            drv_b[i] = 16'h0001;
            exp_q.push_back({3'(i), (i == NP - 1), 16'h007F, 16'h0080});
        end
        run_line(1'b1, 1, -1, -1, 1'b1, "wrap_inv");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
